alu_pipe: RTL

- Parametrised, pipelined integer ALU with valid/ready handshakes on input and output.
- Extends the base 8-operation ALU with four things:
  - explicit operand width (no implicit +1 bit);
  - shift and compare operations;
  - signed overflow and negative flags;
  - configurable pipeline depth with full backpressure.
- Sits between the operand-fetch stage and the writeback stage of the datapath. The datapath may issue one operation per cycle.

---
 rtl/alu_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU with valid/ready handshakes on both sides.
// Ports: clk, rstn, in_valid/in_ready/opcode/op1/op2 in; out_valid/out_ready/result/flags out.
`timescale 1ns/1ps
module alu_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int PIPE_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   op1,
  input  logic [DATA_WIDTH-1:0]   op2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    carry,
  output logic                    zero,
  output logic                    negative,
  output logic                    overflow,
  output logic                    illegal
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam int P  = PIPE_STAGES;

  typedef logic [OPCODE_WIDTH-1:0] op_t;

  localparam op_t OP_ADD  = op_t'(0);
  localparam op_t OP_SUB  = op_t'(1);
  localparam op_t OP_INC  = op_t'(2);
  localparam op_t OP_DEC  = op_t'(3);
  localparam op_t OP_AND  = op_t'(4);
  localparam op_t OP_OR   = op_t'(5);
  localparam op_t OP_NAND = op_t'(6);
  localparam op_t OP_XOR  = op_t'(7);
  localparam op_t OP_SHL  = op_t'(8);
  localparam op_t OP_SHR  = op_t'(9);
  localparam op_t OP_SRA  = op_t'(10);
  localparam op_t OP_SLT  = op_t'(11);
  localparam op_t OP_SLTU = op_t'(12);

  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MSB     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = ~MSB;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         illegal;
  } alu_out_t;

  logic [SW-1:0] sh;
  logic [W:0]    sum;
  logic [W:0]    diff;
  logic [W:0]    shl_x;
  logic [W:0]    shr_x;
  logic [W:0]    sra_x;
  logic [W-1:0]  res;
  logic          cy;
  logic          ov;
  logic          ill;
  alu_out_t      eval;

  assign sh   = op2[SW-1:0];
  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign diff = {1'b0, op1} - {1'b0, op2};

  // Shifts run one bit wider so the last bit shifted out
  // lands in the extra bit; a zero shift leaves it at 0.
  assign shl_x = {1'b0, op1} << sh;
  assign shr_x = {op1, 1'b0} >> sh;
  assign sra_x = $signed({op1, 1'b0}) >>> sh;

  always_comb begin
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        res = sum[W-1:0];
        cy  = sum[W];
        ov  = (op1[W-1] == op2[W-1]) &&
              (sum[W-1] != op1[W-1]);
      end
      (opcode == OP_SUB): begin
        res = diff[W-1:0];
        cy  = diff[W];
        ov  = (op1[W-1] != op2[W-1]) &&
              (diff[W-1] != op1[W-1]);
      end
      (opcode == OP_INC): begin
        res = op1 + ONE;
        cy  = &op1;
        ov  = (op1 == MAX_POS);
      end
      (opcode == OP_DEC): begin
        res = op1 - ONE;
        cy  = (op1 == '0);
        ov  = (op1 == MSB);
      end
      (opcode == OP_AND):  res = op1 & op2;
      (opcode == OP_OR):   res = op1 | op2;
      (opcode == OP_NAND): res = ~(op1 & op2);
      (opcode == OP_XOR):  res = op1 ^ op2;
      (opcode == OP_SHL): begin
        res = shl_x[W-1:0];
        cy  = shl_x[W];
      end
      (opcode == OP_SHR): begin
        res = shr_x[W:1];
        cy  = shr_x[0];
      end
      (opcode == OP_SRA): begin
        res = sra_x[W:1];
        cy  = sra_x[0];
      end
      (opcode == OP_SLT):
        res = {{(W-1){1'b0}},
               $signed(op1) < $signed(op2)};
      (opcode == OP_SLTU):
        res = {{(W-1){1'b0}}, op1 < op2};
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    eval.result   = res;
    eval.carry    = cy;
    eval.zero     = (res == '0);
    eval.negative = res[W-1];
    eval.overflow = ov;
    eval.illegal  = ill;
  end

  alu_out_t     st_data [P];
  logic [P-1:0] st_vld;
  logic [P-1:0] adv;
  logic [P-1:0] load;

  // A stage moves on when it holds data and the next stage
  // is empty or moving on too; this ripples back from out_ready.
  always_comb begin
    adv = '0;
    adv[P-1] = st_vld[P-1] && out_ready;
    for (int k = P - 2; k >= 0; k--) begin
      adv[k] = st_vld[k] && (!st_vld[k+1] || adv[k+1]);
    end
  end

  assign in_ready = !st_vld[0] || adv[0];

  always_comb begin
    load = '0;
    load[0] = in_valid && in_ready;
    for (int k = 1; k < P; k++) begin
      load[k] = adv[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_vld <= '0;
      for (int k = 0; k < P; k++) begin
        st_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < P; k++) begin
        if (load[k]) begin
          st_vld[k] <= 1'b1;
        end else if (adv[k]) begin
          st_vld[k] <= 1'b0;
        end
      end
      if (load[0]) begin
        st_data[0] <= eval;
      end
      for (int k = 1; k < P; k++) begin
        if (load[k]) begin
          st_data[k] <= st_data[k-1];
        end
      end
    end
  end

  assign out_valid = st_vld[P-1];
  assign result    = st_data[P-1].result;
  assign carry     = st_data[P-1].carry;
  assign zero      = st_data[P-1].zero;
  assign negative  = st_data[P-1].negative;
  assign overflow  = st_data[P-1].overflow;
  assign illegal   = st_data[P-1].illegal;

endmodule
